btn_debounce: RTL



---
 rtl/btn_debounce_if.sv | 12 +
 rtl/btn_debounce.sv | 123 ++++++++++++
 2 files changed

// File: rtl/btn_debounce_if.sv
// Signal bundle between the debouncer and its surroundings:
// the raw level comes in, and the clean level, edge pulses and press count go out.
interface btn_debounce_if;
  logic       A;
  logic       Y;
  logic       RISE;
  logic       FALL;
  logic [7:0] COUNT;

  modport master (output A, input Y, input RISE, input FALL, input COUNT);
  modport slave  (input A, output Y, output RISE, output FALL, output COUNT);
endinterface

// File: rtl/btn_debounce.sv
// Push-button debouncer: two-flop synchroniser, stability-count FSM,
// registered clean level, one-cycle edge pulses and an 8-bit press counter.
module btn_debounce #(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  btn_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q, y_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [7:0]       count_q, count_d;

  // Synchroniser and FSM/output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= STABLE_LO;
      cnt_q   <= CNT_ZERO;
      y_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      s1_q    <= bus.A;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: a new level must be seen on every one of STABLE_CYCLES
  // consecutive samples; a single opposite sample abandons the change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    count_d = count_q;
    case (state_q)
      STABLE_LO: begin
        y_d = 1'b0;
        if (s2_q) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT_HI: begin
        if (!s2_q) begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
          y_d     = 1'b1;
          rise_d  = 1'b1;
          count_d = count_q + 8'd1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        y_d = 1'b1;
        if (!s2_q) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT_LO: begin
        if (s2_q) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
          y_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = CNT_ZERO;
        y_d     = 1'b0;
      end
    endcase
  end

  assign bus.Y     = y_q;
  assign bus.RISE  = rise_q;
  assign bus.FALL  = fall_q;
  assign bus.COUNT = count_q;

endmodule
